// File: rtl/global_types.sv
// rtl/global_types.sv - shared state encoding and constants for dmem_bridge
package global_types;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DRAIN,
    ST_RESP
  } dmem_state_t;

  localparam int          TIMEOUT_W   = 16;
  localparam logic [31:0] DMEM_RD_ERR = 32'h0;

endpackage

// File: rtl/dmem_timeout.sv
// rtl/dmem_timeout.sv - loadable down-counter flagging a memory ack that never came
import global_types::*;

module dmem_timeout #(
  parameter logic [TIMEOUT_W-1:0] LOAD = 16'd254
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = LOAD;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // LOAD is one less than the wait limit, so zero is reached on the last allowed cycle.
  assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - datapath to backing-memory req/ack bridge with stall generation
// Optional posted-write buffer: define DMEM_WRITE_BUFFER_EN.
import global_types::*;

module dmem_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        re,
  input  logic        we,
  output logic [31:0] rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err_misaligned,
  output logic        err_timeout
);

`ifdef DMEM_WRITE_BUFFER_EN
  localparam bit WBUF_EN = 1'b1;
`else
  localparam bit WBUF_EN = 1'b0;
`endif

  localparam logic [TIMEOUT_W-1:0] TO_LOAD = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  dmem_state_t state_q, state_d;
  logic [31:0] rd_q, rd_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        err_mis_q, err_mis_d;
  logic        err_to_q, err_to_d;

  logic access;
  logic aligned;
  logic handshake;
  logic expired;
  logic waiting;

  assign access    = re | we;
  assign aligned   = (addr[1:0] == 2'b00);
  assign handshake = mem_req_q & mem_ack;
  assign waiting   = (state_q == ST_READ) || (state_q == ST_WRITE) || (state_q == ST_DRAIN);

  dmem_timeout #(.LOAD(TO_LOAD)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_d != state_q),
    .enable  (waiting),
    .expired (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_mis_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_mis_q   <= err_mis_d;
      err_to_q    <= err_to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (access && aligned) begin
          if (we) begin
            state_d = WBUF_EN ? ST_DRAIN : ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ, ST_WRITE: begin
        if (handshake || expired) state_d = ST_RESP;
      end
      ST_DRAIN: begin
        if (handshake || expired) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_mis_d   = err_mis_q;
    err_to_d    = err_to_q;
    case (state_q)
      ST_IDLE: begin
        if (access && !aligned) begin
          rd_d      = DMEM_RD_ERR;
          err_mis_d = 1'b1;
        end else if (access) begin
          // A buffered store retires immediately; everything else waits for the ack.
          stall       = !(WBUF_EN && we);
          mem_req_d   = 1'b1;
          mem_we_d    = we;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_wdata_d = wd;
        end
      end
      ST_READ, ST_WRITE: begin
        stall = 1'b1;
        if (handshake) begin
          mem_req_d = 1'b0;
          if (state_q == ST_READ) rd_d = mem_rdata;
        end else if (expired) begin
          mem_req_d = 1'b0;
          err_to_d  = 1'b1;
          if (state_q == ST_READ) rd_d = DMEM_RD_ERR;
        end
      end
      ST_DRAIN: begin
        // Any new memory instruction waits for the drain; no forwarding from the buffer.
        stall = access;
        if (handshake) begin
          mem_req_d = 1'b0;
        end else if (expired) begin
          mem_req_d = 1'b0;
          err_to_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rd             = rd_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - self-checking bench for dmem_bridge (define DMEM_WRITE_BUFFER_EN for the buffered build)
`timescale 1ns/1ps
module tb_dmem_bridge;

  localparam int T = 4;

`ifdef DMEM_WRITE_BUFFER_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [31:0] rd;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err_misaligned;
  logic        err_timeout;

  dmem_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clock          (clock),
    .reset          (reset),
    .addr           (addr),
    .wd             (wd),
    .re             (re),
    .we             (we),
    .rd             (rd),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .err_misaligned (err_misaligned),
    .err_timeout    (err_timeout)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // backing memory, acked after a per-transaction delay taken from dly_q
  logic [31:0] mem [int unsigned];
  int          dly_q[$];
  int          req_cnt = 0;
  int          cur_dly = 0;
  int          total_reqs = 0;
  int          unstable = 0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic        cap_we = 1'b0;

  // reference model state
  logic [31:0] exp_mem [int unsigned];
  logic [31:0] exp_rd = '0;
  bit          exp_mis = 1'b0;
  bit          exp_to = 1'b0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (exp_mem.exists(a[31:2])) return exp_mem[a[31:2]];
    return dflt(a);
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (reset || !mem_req) begin
        req_cnt = 0;
      end else begin
        if (req_cnt == 0) begin
          cur_dly   = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
          cap_addr  = mem_addr;
          cap_wdata = mem_wdata;
          cap_we    = mem_we;
        end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_we !== cap_we) begin
          unstable++;
        end
        req_cnt++;
        total_reqs++;
        if (req_cnt == cur_dly + 1) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr[31:2]] = mem_wdata;
          else mem_rdata = mem.exists(mem_addr[31:2]) ? mem[mem_addr[31:2]] : dflt(mem_addr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one instruction until the datapath would commit (stall low), then retire it.
  task automatic access(input bit w, input bit both, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rd_commit,
                        output logic [31:0] rd_after, output bit done);
    stalls = 0;
    done = 1'b0;
    rd_commit = '0;
    re = !w || both;
    we = w;
    addr = a;
    wd = d;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (stall) stalls++;
      else begin
        done = 1'b1;
        rd_commit = rd;
      end
      @(posedge clock);
      #1;
    end
    re = 1'b0;
    we = 1'b0;
    rd_after = rd;
  endtask

  task automatic drain_wait();
    for (int c = 0; c < 64 && mem_req; c++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic run(input bit w, input bit both, input logic [31:0] a, input logic [31:0] d,
                     input int dly, input string tag);
    int          st, r0, exp_st, exp_req;
    logic [31:0] rc, ra;
    bit          done;
    bit          al;
    al = (a[1:0] == 2'b00);
    if (al) dly_q.push_back(dly);
    r0 = total_reqs;
    access(w, both, a, d, st, rc, ra, done);
    drain_wait();
    if (!al) begin
      exp_st = 0;
      exp_req = 0;
      exp_mis = 1'b1;
      exp_rd = '0;
    end else if (dly >= T) begin
      exp_req = T;
      exp_st = (w && WBUF) ? 0 : T + 1;
      exp_to = 1'b1;
      if (!w) exp_rd = '0;
    end else begin
      exp_req = dly + 1;
      exp_st = (w && WBUF) ? 0 : dly + 2;
      if (w) exp_mem[a[31:2]] = d;
      else exp_rd = model_read(a);
    end
    check({tag, ".done"}, 32'(done), 32'(1));
    check({tag, ".stall_cycles"}, st, exp_st);
    check({tag, ".mem_reqs"}, total_reqs - r0, exp_req);
    check({tag, ".rd"}, ra, exp_rd);
    check({tag, ".err_misaligned"}, 32'(err_misaligned), 32'(exp_mis));
    check({tag, ".err_timeout"}, 32'(err_timeout), 32'(exp_to));
    check({tag, ".mem_req_idle"}, 32'(mem_req), 32'(0));
    if (al) begin
      check({tag, ".mem_addr"}, cap_addr, a);
      check({tag, ".mem_we"}, 32'(cap_we), 32'(w));
      if (w) check({tag, ".mem_wdata"}, cap_wdata, d);
      else check({tag, ".rd_in_resp"}, rc, exp_rd);
    end
  endtask

  initial begin
    int          st;
    logic [31:0] rc, ra, d, a;
    bit          done, w, both;
    int          dly;

    mem[32'h10 >> 2] = 32'hCAFE_F00D;
    exp_mem[32'h10 >> 2] = 32'hCAFE_F00D;

    repeat (2) @(posedge clock);
    #1;
    check("reset.rd", rd, 32'h0);
    check("reset.stall", 32'(stall), 32'(0));
    check("reset.mem_req", 32'(mem_req), 32'(0));
    check("reset.mem_we", 32'(mem_we), 32'(0));
    check("reset.mem_addr", mem_addr, 32'h0);
    check("reset.mem_wdata", mem_wdata, 32'h0);
    check("reset.err_misaligned", 32'(err_misaligned), 32'(0));
    check("reset.err_timeout", 32'(err_timeout), 32'(0));
    reset = 1'b0;
    @(posedge clock);
    #1;

    run(1'b0, 1'b0, 32'h0000_0010, 32'h0, 0, "load_zero_wait");
    run(1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 3, "store_delay3");
    check("store_delay3.stable", unstable, 0);
    run(1'b0, 1'b0, 32'h0000_0020, 32'h0, 1, "load_back_store");
    run(1'b0, 1'b0, 32'h0000_0013, 32'h0, 0, "load_misaligned");
    run(1'b0, 1'b0, 32'h0000_0010, 32'h0, 2, "mis_held");
    run(1'b0, 1'b0, 32'h0000_0044, 32'h0, 100, "load_timeout");
    run(1'b1, 1'b1, 32'h0000_0048, 32'hA5A5_0001, 0, "store_re_we");

    // reset while a read is outstanding
    dly_q.push_back(100);
    re = 1'b1;
    addr = 32'h0000_0080;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    check("midreset.req_before", 32'(mem_req), 32'(1));
    #1;
    reset = 1'b1;
    #1;
    check("midreset.mem_req", 32'(mem_req), 32'(0));
    check("midreset.mem_addr", mem_addr, 32'h0);
    check("midreset.rd", rd, 32'h0);
    check("midreset.err_misaligned", 32'(err_misaligned), 32'(0));
    check("midreset.err_timeout", 32'(err_timeout), 32'(0));
    re = 1'b0;
    #1;
    check("midreset.stall", 32'(stall), 32'(0));
    exp_rd = '0;
    exp_mis = 1'b0;
    exp_to = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    run(1'b0, 1'b0, 32'h0000_0010, 32'h0, 0, "load_after_reset");

`ifdef DMEM_WRITE_BUFFER_EN
    // store immediately followed by a load of the same word during DRAIN
    d = $urandom;
    dly_q.push_back(2);
    dly_q.push_back(1);
    access(1'b1, 1'b0, 32'h0000_0060, d, st, rc, ra, done);
    check("wbuf.store_stalls", st, 0);
    exp_mem[32'h60 >> 2] = d;
    access(1'b0, 1'b0, 32'h0000_0060, 32'h0, st, rc, ra, done);
    drain_wait();
    exp_rd = d;
    check("wbuf.load_stalls", st, (2 + 1) + 2 + 1);
    check("wbuf.load_rd", ra, d);
    check("wbuf.load_done", 32'(done), 32'(1));
`endif

    for (int i = 0; i < 16; i++) begin
      w = 1'(($urandom_range(0, 1)));
      both = w && ($urandom_range(0, 2) == 0);
      a = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
      d = $urandom;
      dly = $urandom_range(0, 3);
      run(w, both, a, d, dly, $sformatf("rand%0d", i));
    end
    check("final.stable", unstable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge sitting directly downstream of the MIPS datapath. It consumes the datapath's ALU result as the address and the register-file read port 2 value as write data. It runs a req/ack handshake to a variable-latency backing memory and returns read data to the result mux. It also raises `stall` to freeze the PC and register-file write while an access is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 255: ack wait limit per transaction; range 1..65535.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `addr` in 32: byte address, from the datapath `alu_out`.
- `wd` in 32: store data, from the datapath `dmem_wd`.
- `re` in 1: load request from the control unit.
- `we` in 1: store request from the control unit.
- `rd` out 32: load data, registered, to the result mux.
- `stall` out 1: hold PC and block RF write.
- `mem_req` out 1: memory request, registered.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out 32: word-aligned address.
- `mem_wdata` out 32: write data.
- `mem_ack` in 1: transfer complete; sampled only while `mem_req`=1.
- `mem_rdata` in 32: valid on the edge where `mem_req & mem_ack`.
- `err_misaligned` out 1: sticky flag.
- `err_timeout` out 1: sticky flag.

## Operation
- States:
  - IDLE: no transaction.
  - READ: read request outstanding.
  - WRITE: write request outstanding.
  - DRAIN: buffered write outstanding.
  - RESP: one-cycle completion.
- IDLE:
  - `re|we` with aligned address → `stall`=1 combinationally.
  - Latch addr/wd/we; go READ or WRITE.
  - `re&we` both set → treated as a write.
- READ/WRITE:
  - `mem_req`=1 and mem_* stable until handshake.
  - On `mem_req&mem_ack`: READ captures `mem_rdata` into `rd`; go RESP.
- RESP:
  - `stall`=0 and `rd` valid; the datapath commits on this edge.
  - Next state IDLE.
- Misaligned access (`addr[1:0]`≠0 with `re|we`):
  - No memory request is issued.
  - `stall`=0, `rd`=0, store suppressed.
  - `err_misaligned` set.
- Timeout:
  - A counter runs in READ/WRITE/DRAIN.
  - After `TIMEOUT_CYCLES` cycles without ack: drop `mem_req`, set `err_timeout`.
  - Read returns `rd`=0; go RESP (from DRAIN, go IDLE).
- Sticky errors clear only on `reset`.
- `re`=`we`=0 → `stall`=0, no request.

## Timing
- Reset values: `rd`=0, `stall`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, both err=0; state IDLE, counter 0, buffer empty.
- Minimum load latency with zero-wait ack:
  - Request in cycle N (IDLE, stall=1).
  - Cycle N+1 READ with ack (stall=1).
  - Cycle N+2 RESP (stall=0).
  - Total 3 cycles, 2 stalled.
- Each cycle of `mem_ack` delay adds one stall cycle.
- `mem_ack` while `mem_req`=0 is ignored.
- Reset mid-transaction: immediate return to IDLE, `mem_req` low asynchronously, buffered write discarded.
- Timeout counter is 16-bit; it resets on every state entry.

## Configuration
- `DMEM_WRITE_BUFFER_EN` defined:
  - Aligned store in IDLE fills a one-entry posted-write buffer with `stall`=0 that cycle; go DRAIN.
  - In DRAIN, non-memory instructions run unstalled.
  - Any `re|we` in DRAIN stalls until the drain ack, then starts from IDLE. No read forwarding.
- Undefined: stores use the blocking WRITE→RESP path, same latency as loads.

## Structure
- Shared package (`global_types`):
  - `dmem_state_t` enum.
  - `TIMEOUT_W`=16.
  - `DMEM_RD_ERR`=32'h0 read value on error.
- Sub-module `dmem_timeout`: loadable down-counter.
  - Inputs: `clock`, `reset`, `clear`, `enable`.
  - Output: `expired`.

## Test plan
- Load addr 32'h0000_0010, memory acks 1st cycle with 32'hCAFE_F00D → stall high 2 cycles, `rd`=32'hCAFE_F00D in RESP, then IDLE.
- Store addr 32'h20, wd 32'h1234_5678, ack delayed 3 cycles → `mem_we`=1, stable addr/data for 4 cycles, stall released in RESP; with `DMEM_WRITE_BUFFER_EN`, stall=0 at issue.
- Load addr 32'h0000_0013 → no `mem_req`, `rd`=0, `stall`=0, `err_misaligned`=1 and held.
- `TIMEOUT_CYCLES`=4, ack never asserted → `mem_req` drops after 4 cycles, `err_timeout`=1, `rd`=0.
- Assert `reset` in READ → `mem_req`=0 same cycle, all outputs at reset values; next load completes normally.
- `DMEM_WRITE_BUFFER_EN`: store then immediate load during DRAIN → load stalls until store ack, then the load completes with correct data.
